// File: rtl/keypad_entry.sv
// ============================================================================
// Module   : keypad_entry
// Purpose  : 4x4 matrix keypad scanner with debounce, key decode, two-digit
//            BCD entry accumulator and one-cycle command strobes.
//            Optional idle timeout enabled by macro KEYPAD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int TIMEOUT_CYCLES = 30000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_row_in,
  output logic [3:0] o_col_out,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic [3:0] o_entry_tens,
  output logic [3:0] o_entry_ones,
  output logic [1:0] o_entry_cnt,
  output logic       o_entry_done,
  output logic       o_cmd_valid,
  output logic [1:0] o_cmd_code,
  output logic       o_entry_timeout
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] c_SLOT_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] c_DEB_MAX  = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_sync, r_rs;
  logic [SW-1:0]   r_slot;
  logic [1:0]      r_col_idx, w_col_nxt;
  logic [DW-1:0]   r_deb_cnt, w_deb_nxt, w_deb_inc;
  logic [3:0]      r_row_lat, w_row_nxt;
  logic            w_sample, w_one_low, w_accept;
  logic [1:0]      w_row_idx;
  logic [3:0]      w_key_code;
  logic            w_timeout_hit;

  logic            r_key_valid, r_entry_done, r_cmd_valid, r_entry_timeout;
  logic [3:0]      r_key_code, r_tens, r_ones;
  logic [1:0]      r_cnt, r_cmd_code;
  logic            r_done;

  // Rows are asynchronous to clk; two flops before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 4'hF;
      r_rs   <= 4'hF;
    end else begin
      r_sync <= i_row_in;
      r_rs   <= r_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_slot <= '0;
    else if (r_slot == c_SLOT_MAX) r_slot <= '0;
    else r_slot <= r_slot + SW'(1);
  end

  assign w_sample  = (r_slot == c_SLOT_MAX);
  assign w_one_low = (r_rs == 4'b1110) || (r_rs == 4'b1101) ||
                     (r_rs == 4'b1011) || (r_rs == 4'b0111);
  assign w_deb_inc = r_deb_cnt + DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_SCAN;
      r_col_idx <= 2'd0;
      r_deb_cnt <= '0;
      r_row_lat <= 4'hF;
    end else begin
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_row_lat <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_deb_nxt   = r_deb_cnt;
    w_row_nxt   = r_row_lat;
    w_accept    = 1'b0;
    if (w_sample) begin
      case (r_state)
        S_SCAN: begin
          if (w_one_low) begin
            w_row_nxt   = r_rs;
            w_deb_nxt   = DW'(1);
            w_state_nxt = S_DEBOUNCE;
          end else begin
            w_col_nxt = r_col_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (r_rs == r_row_lat) begin
            if (w_deb_inc == c_DEB_MAX) begin
              w_deb_nxt   = '0;
              w_state_nxt = S_HELD;
              w_accept    = 1'b1;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_deb_nxt   = '0;
            w_col_nxt   = r_col_idx + 2'd1;
            w_state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          // Release needs the same number of clean all-high samples as a press.
          if (r_rs == 4'hF) begin
            if (w_deb_inc == c_DEB_MAX) begin
              w_deb_nxt   = '0;
              w_col_nxt   = r_col_idx + 2'd1;
              w_state_nxt = S_SCAN;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
        default: begin
          w_deb_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      endcase
    end
  end

  always_comb begin
    case (r_row_lat)
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    case ({w_row_idx, r_col_idx})
      4'h0:    w_key_code = 4'd1;
      4'h1:    w_key_code = 4'd2;
      4'h2:    w_key_code = 4'd3;
      4'h3:    w_key_code = 4'd10;
      4'h4:    w_key_code = 4'd4;
      4'h5:    w_key_code = 4'd5;
      4'h6:    w_key_code = 4'd6;
      4'h7:    w_key_code = 4'd11;
      4'h8:    w_key_code = 4'd7;
      4'h9:    w_key_code = 4'd8;
      4'hA:    w_key_code = 4'd9;
      4'hB:    w_key_code = 4'd12;
      4'hC:    w_key_code = 4'd14;
      4'hD:    w_key_code = 4'd0;
      4'hE:    w_key_code = 4'd15;
      default: w_key_code = 4'd13;
    endcase
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_idle;

  assign w_timeout_hit = !w_accept && (r_cnt != 2'd0) && (r_idle == c_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idle <= '0;
    else if (w_accept || w_timeout_hit || (r_cnt == 2'd0)) r_idle <= '0;
    else r_idle <= r_idle + TW'(1);
  end
`else
  // Constant 0; the parameter is referenced so both builds share one interface.
  assign w_timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid     <= 1'b0;
      r_key_code      <= 4'd0;
      r_entry_done    <= 1'b0;
      r_cmd_valid     <= 1'b0;
      r_cmd_code      <= 2'd0;
      r_entry_timeout <= 1'b0;
      r_tens          <= 4'd0;
      r_ones          <= 4'd0;
      r_cnt           <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      r_key_valid     <= w_accept;
      r_entry_done    <= 1'b0;
      r_cmd_valid     <= 1'b0;
      r_entry_timeout <= 1'b0;
      if (w_accept) begin
        r_key_code <= w_key_code;
        if (w_key_code <= 4'd9) begin
          // A finished entry is replaced rather than extended.
          if (r_done) begin
            r_tens <= 4'd0;
            r_ones <= w_key_code;
            r_cnt  <= 2'd1;
            r_done <= 1'b0;
          end else if (r_cnt < 2'd2) begin
            r_tens <= r_ones;
            r_ones <= w_key_code;
            r_cnt  <= r_cnt + 2'd1;
          end
        end else if (w_key_code == 4'd14) begin
          r_tens <= 4'd0;
          r_ones <= 4'd0;
          r_cnt  <= 2'd0;
          r_done <= 1'b0;
        end else if (w_key_code == 4'd15) begin
          if (r_cnt != 2'd0) begin
            r_entry_done <= 1'b1;
            r_cnt        <= 2'd0;
            r_done       <= 1'b1;
          end
        end else begin
          r_cmd_valid <= 1'b1;
          r_cmd_code  <= 2'(w_key_code - 4'd10);
        end
      end else if (w_timeout_hit) begin
        r_tens          <= 4'd0;
        r_ones          <= 4'd0;
        r_cnt           <= 2'd0;
        r_entry_timeout <= 1'b1;
      end
    end
  end

  assign o_col_out       = ~(4'b0001 << r_col_idx);
  assign o_key_valid     = r_key_valid;
  assign o_key_code      = r_key_code;
  assign o_entry_tens    = r_tens;
  assign o_entry_ones    = r_ones;
  assign o_entry_cnt     = r_cnt;
  assign o_entry_done    = r_entry_done;
  assign o_cmd_valid     = r_cmd_valid;
  assign o_cmd_code      = r_cmd_code;
  assign o_entry_timeout = r_entry_timeout;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
// Module   : tb_keypad_entry
// Purpose  : Directed self-checking bench for keypad_entry with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid, entry_done, cmd_valid, entry_timeout;
  logic [3:0] key_code, entry_tens, entry_ones;
  logic [1:0] entry_cnt, cmd_code;

  logic       pressed, raw_mode;
  logic [1:0] kr, kc;
  logic [3:0] raw_rows;
  logic [3:0] c0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_kv = 0, n_done = 0, n_cmd = 0, n_to = 0, n_viol = 0;
  int kv0, done0, cmd0;

  keypad_entry #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_row_in       (row_in),
    .o_col_out      (col_out),
    .o_key_valid    (key_valid),
    .o_key_code     (key_code),
    .o_entry_tens   (entry_tens),
    .o_entry_ones   (entry_ones),
    .o_entry_cnt    (entry_cnt),
    .o_entry_done   (entry_done),
    .o_cmd_valid    (cmd_valid),
    .o_cmd_code     (cmd_code),
    .o_entry_timeout(entry_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_in = 4'hF;
    if (raw_mode) row_in = raw_rows;
    else if (pressed && (col_out[kc] == 1'b0)) row_in[kr] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid)     n_kv++;
      if (entry_done)    n_done++;
      if (cmd_valid)     n_cmd++;
      if (entry_timeout) n_to++;
      if ((int'(entry_done) + int'(cmd_valid) + int'(entry_timeout)) > 1) n_viol++;
      if ((entry_done || cmd_valid) && !key_valid) n_viol++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    kr = r;
    kc = c;
    pressed = 1'b1;
    step(80);
    pressed = 1'b0;
    step(40);
  endtask

  task automatic check_entry(input string tag, input int t, input int o, input int n);
    check({tag, "_tens"}, int'(entry_tens), t);
    check({tag, "_ones"}, int'(entry_ones), o);
    check({tag, "_cnt"},  int'(entry_cnt),  n);
  endtask

  initial begin
    rst_n    = 1'b0;
    pressed  = 1'b0;
    raw_mode = 1'b0;
    raw_rows = 4'hF;
    kr = 2'd0;
    kc = 2'd0;
    step(3);
    check("rst_col", int'(col_out), 14);
    check("rst_kv", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check_entry("rst", 0, 0, 0);
    check("rst_cmd", int'(cmd_code), 0);
    check("rst_to", int'(entry_timeout), 0);

    // Idle scan: column moves on every 4th edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("scan_c0", int'(col_out), 14);
    step(1);
    check("scan_c1", int'(col_out), 13);
    step(4);
    check("scan_c2", int'(col_out), 11);
    step(4);
    check("scan_c3", int'(col_out), 7);
    step(4);
    check("scan_wrap", int'(col_out), 14);
    check("idle_kv", n_kv, 0);

    // Bounce: low 1 sample, high 1, low 2, released.
    raw_mode = 1'b1;
    raw_rows = 4'b1110;
    step(4);
    raw_rows = 4'hF;
    step(4);
    raw_rows = 4'b1110;
    step(8);
    raw_rows = 4'hF;
    step(20);
    raw_mode = 1'b0;
    check("bounce_kv", n_kv, 0);

    // Key '6'
    press_key(2'd1, 2'd2);
    check("k6_kv", n_kv, 1);
    check("k6_code", int'(key_code), 6);
    check_entry("k6", 0, 6, 1);
    c0 = col_out;
    step(4);
    check("k6_rescan", int'(col_out), int'({c0[2:0], c0[3]}));

    press_key(2'd3, 2'd0);
    check("star_code", int'(key_code), 14);
    check_entry("star1", 0, 0, 0);

    done0 = n_done;
    press_key(2'd1, 2'd0);
    check_entry("d4", 0, 4, 1);
    press_key(2'd0, 2'd1);
    check_entry("d42", 4, 2, 2);
    kv0 = n_kv;
    press_key(2'd2, 2'd0);
    check("d7_kv", n_kv, kv0 + 1);
    check("d7_code", int'(key_code), 7);
    check_entry("d7_ign", 4, 2, 2);
    press_key(2'd3, 2'd2);
    check("hash_done", n_done, done0 + 1);
    check_entry("hash", 4, 2, 0);
    press_key(2'd1, 2'd1);
    check_entry("d5", 0, 5, 1);

    cmd0 = n_cmd;
    press_key(2'd2, 2'd3);
    check("cmdC_n", n_cmd, cmd0 + 1);
    check("cmdC_code", int'(cmd_code), 2);
    check("cmdC_kcode", int'(key_code), 12);
    check_entry("cmdC", 0, 5, 1);

    press_key(2'd3, 2'd0);
    check_entry("star2", 0, 0, 0);
    check("done_total", n_done, done0 + 1);

    // '#' with nothing entered: no entry_done
    press_key(2'd3, 2'd2);
    check("hash_empty", n_done, done0 + 1);

    // Two rows low at once is not a key
    kv0 = n_kv;
    raw_mode = 1'b1;
    raw_rows = 4'b1100;
    step(60);
    c0 = col_out;
    step(4);
    check("dual_rescan", int'(col_out), int'({c0[2:0], c0[3]}));
    raw_rows = 4'hF;
    step(12);
    raw_mode = 1'b0;
    check("dual_kv", n_kv, kv0);

    press_key(2'd0, 2'd2);
    check("d3_code", int'(key_code), 3);
    step(200);
`ifdef KEYPAD_TIMEOUT_EN
    check("to_n", n_to, 1);
    check_entry("to", 0, 0, 0);
`else
    check("to_n", n_to, 0);
    check_entry("noto", 0, 3, 1);
`endif
    check("to_out", int'(entry_timeout), 0);

    // Reset while '8' is held, then re-acceptance after full debounce
    kr = 2'd2;
    kc = 2'd1;
    pressed = 1'b1;
    step(60);
    check("r8_pre", int'(key_code), 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col", int'(col_out), 14);
    check("mid_rst_code", int'(key_code), 0);
    check_entry("mid_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    kv0 = n_kv;
    step(60);
    check("r8_again", n_kv, kv0 + 1);
    check("r8_code", int'(key_code), 8);
    check_entry("r8", 0, 8, 1);
    pressed = 1'b0;
    step(40);

    check("strobe_excl", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
